// File: rtl/edge_capture_unit.sv
// Multi-channel edge capture: per-channel synchroniser, glitch filter, qualified
// edge pulse, sticky flag and saturating event counter.
module edge_capture_unit #(
  parameter int unsigned NB_CHANNELS   = 10,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic [NB_CHANNELS-1:0]       sig_i,
  input  logic [2*NB_CHANNELS-1:0]     mode_i,
  input  logic [NB_CHANNELS-1:0]       clr_ch_i,
  output logic [NB_CHANNELS-1:0]       level_o,
  output logic [NB_CHANNELS-1:0]       edge_pulse_o,
  output logic [NB_CHANNELS-1:0]       edge_flag_o,
  output logic [NB_CHANNELS*CNT_W-1:0] edge_cnt_o,
  output logic                         any_flag_o
);

  localparam int unsigned      FLT_MAX  = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
  localparam int unsigned      FLT_W    = (FLT_MAX <= 1) ? 1 : $clog2(FLT_MAX);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FLT_MAX - 1);
  localparam logic [FLT_W-1:0] FLT_ONE  = FLT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NB_CHANNELS-1:0] synced;
  logic [NB_CHANNELS-1:0] toggle;
  logic [NB_CHANNELS-1:0] qual;
  logic [NB_CHANNELS-1:0] clear;
  logic [FLT_W-1:0]       flt_cnt [NB_CHANNELS];
  logic [CNT_W-1:0]       ev_cnt  [NB_CHANNELS];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign synced = sig_i;
    end else begin : g_sync
      logic [NB_CHANNELS-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
          end
        end else begin
          sync_q[0] <= sig_i;
          for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
          end
        end
      end

      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // A toggle is decided on the edge where the mismatch has persisted long
  // enough; direction is taken from the level before that edge.
  always_comb begin
    toggle = '0;
    qual   = '0;
    for (int unsigned i = 0; i < NB_CHANNELS; i++) begin
      toggle[i] = (synced[i] != level_o[i]) && (flt_cnt[i] == FLT_LAST);
      qual[i]   = toggle[i] && (level_o[i] ? mode_i[2*i+1] : mode_i[2*i]);
    end
  end

  assign clear = clr_ch_i | {NB_CHANNELS{clr_i}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_o <= '0;
      for (int unsigned i = 0; i < NB_CHANNELS; i++) begin
        flt_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NB_CHANNELS; i++) begin
        if ((synced[i] == level_o[i]) || toggle[i]) begin
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + FLT_ONE;
        end
      end
      level_o <= level_o ^ toggle;
    end
  end

  // An event on the same edge as a clear wins and restarts the count at one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      edge_pulse_o <= '0;
      edge_flag_o  <= '0;
      for (int unsigned i = 0; i < NB_CHANNELS; i++) begin
        ev_cnt[i] <= '0;
      end
    end else begin
      edge_pulse_o <= qual;
      for (int unsigned i = 0; i < NB_CHANNELS; i++) begin
        if (qual[i]) begin
          edge_flag_o[i] <= 1'b1;
          if (clear[i]) begin
            ev_cnt[i] <= CNT_ONE;
          end else if (ev_cnt[i] != CNT_SAT) begin
            ev_cnt[i] <= ev_cnt[i] + CNT_ONE;
          end
        end else if (clear[i]) begin
          edge_flag_o[i] <= 1'b0;
          ev_cnt[i]      <= '0;
        end
      end
    end
  end

  always_comb begin
    edge_cnt_o = '0;
    for (int unsigned i = 0; i < NB_CHANNELS; i++) begin
      edge_cnt_o[CNT_W*i +: CNT_W] = ev_cnt[i];
    end
  end

  assign any_flag_o = |edge_flag_o;

endmodule

// File: tb/tb_edge_capture_unit.sv
// Directed bench for edge_capture_unit: a vector table for the basic capture and
// glitch cases, plus hand sequences for saturation, clears, modes and reset.
module tb_edge_capture_unit;

  localparam int unsigned NB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, clr;
  logic [NB-1:0]   sig, clr_ch;
  logic [2*NB-1:0] mode;

  logic [NB-1:0]   lvl_a, pul_a, flg_a;
  logic [NB*8-1:0] cnt_a;
  logic            any_a;
  logic [NB-1:0]   lvl_b, pul_b, flg_b;
  logic [NB*2-1:0] cnt_b;
  logic            any_b;
  logic [NB-1:0]   lvl_z, pul_z, flg_z;
  logic [NB*8-1:0] cnt_z;
  logic            any_z;

  edge_capture_unit #(.NB_CHANNELS(NB), .SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .sig_i(sig), .mode_i(mode), .clr_ch_i(clr_ch),
    .level_o(lvl_a), .edge_pulse_o(pul_a), .edge_flag_o(flg_a), .edge_cnt_o(cnt_a),
    .any_flag_o(any_a));

  edge_capture_unit #(.NB_CHANNELS(NB), .SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .sig_i(sig), .mode_i(mode), .clr_ch_i(clr_ch),
    .level_o(lvl_b), .edge_pulse_o(pul_b), .edge_flag_o(flg_b), .edge_cnt_o(cnt_b),
    .any_flag_o(any_b));

  edge_capture_unit #(.NB_CHANNELS(NB), .SYNC_STAGES(0), .FILTER_CYCLES(0), .CNT_W(8)) dut_z (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .sig_i(sig), .mode_i(mode), .clr_ch_i(clr_ch),
    .level_o(lvl_z), .edge_pulse_o(pul_z), .edge_flag_o(flg_z), .edge_cnt_o(cnt_z),
    .any_flag_o(any_z));

  typedef struct {
    logic [NB-1:0] sig;
    logic [NB-1:0] exp_lvl;
    logic [NB-1:0] exp_pul;
    logic [NB-1:0] exp_flg;
    int            ch;
    logic [7:0]    exp_cnt;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   ea, na, eb, ez;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  function automatic logic [7:0] ca(input int ch);
    return cnt_a[8*ch +: 8];
  endfunction

  function automatic logic [1:0] cb(input int ch);
    return cnt_b[2*ch +: 2];
  endfunction

  task automatic add(input int n, input logic [NB-1:0] s, input logic [NB-1:0] l,
                     input logic [NB-1:0] p, input logic [NB-1:0] f,
                     input int ch, input logic [7:0] c);
    for (int r = 0; r < n; r++) tbl.push_back('{s, l, p, f, ch, c});
  endtask

  // Runs an 8-edge window; returns first pulse edge per instance and pulse count on dut_a.
  task automatic watch(input int ch, output int fa, output int np, output int fb, output int fz);
    fa = 0; np = 0; fb = 0; fz = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (pul_a[ch]) begin
        np++;
        if (fa == 0) fa = e;
      end
      if (pul_b[ch] && fb == 0) fb = e;
      if (pul_z[ch] && fz == 0) fz = e;
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; clr_ch = '0; sig = '0; mode = '0;
    set_mode(0, 2'b01); set_mode(1, 2'b11); set_mode(2, 2'b11);
    set_mode(3, 2'b01); set_mode(4, 2'b10);

    // ch0 rising capture, then a 3-cycle glitch and a 4-cycle pulse on ch3
    add(5, 10'h001, 10'h000, 10'h000, 10'h000, 0, 8'd0);
    add(1, 10'h001, 10'h001, 10'h001, 10'h001, 0, 8'd1);
    add(1, 10'h001, 10'h001, 10'h000, 10'h001, 0, 8'd1);
    add(3, 10'h009, 10'h001, 10'h000, 10'h001, 3, 8'd0);
    add(5, 10'h001, 10'h001, 10'h000, 10'h001, 3, 8'd0);
    add(4, 10'h009, 10'h001, 10'h000, 10'h001, 3, 8'd0);
    add(1, 10'h001, 10'h001, 10'h000, 10'h001, 3, 8'd0);
    add(1, 10'h001, 10'h009, 10'h008, 10'h009, 3, 8'd1);
    add(3, 10'h001, 10'h009, 10'h000, 10'h009, 3, 8'd1);
    add(2, 10'h001, 10'h001, 10'h000, 10'h009, 3, 8'd1);

    repeat (3) tick();
    chk("rst_lvl", lvl_a, 0);
    chk("rst_pul", pul_a, 0);
    chk("rst_flg", flg_a, 0);
    chk("rst_any", any_a, 0);
    chk("rst_cnt", |cnt_a, 0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      sig = tbl[k].sig;
      tick();
      chk($sformatf("tbl%0d_lvl", k), lvl_a, tbl[k].exp_lvl);
      chk($sformatf("tbl%0d_pul", k), pul_a, tbl[k].exp_pul);
      chk($sformatf("tbl%0d_flg", k), flg_a, tbl[k].exp_flg);
      chk($sformatf("tbl%0d_any", k), any_a, |tbl[k].exp_flg);
      chk($sformatf("tbl%0d_cnt", k), ca(tbl[k].ch), tbl[k].exp_cnt);
    end

    // ch1 both-edge toggles: count saturates at 3 on the 2-bit instance
    for (int k = 1; k <= 5; k++) begin
      sig[1] = ~sig[1];
      watch(1, ea, na, eb, ez);
      chk($sformatf("sat%0d_lat_a", k), ea, 6);
      chk($sformatf("sat%0d_npul", k), na, 1);
      chk($sformatf("sat%0d_lat_b", k), eb, 6);
      chk($sformatf("sat%0d_lat_z", k), ez, 1);
      chk($sformatf("sat%0d_cnt_a", k), ca(1), k);
      chk($sformatf("sat%0d_cnt_b", k), cb(1), (k > 3) ? 3 : k);
      chk($sformatf("sat%0d_flg_b", k), flg_b[1], 1);
    end

    // asynchronous reset while ch0 is mid-filter and ch1 holds count 5
    chk("pre_rst_cnt1", ca(1), 5);
    sig[0] = 1'b0;
    repeat (3) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_lvl", lvl_a, 0);
    chk("arst_pul", pul_a, 0);
    chk("arst_flg", flg_a, 0);
    chk("arst_any", any_a, 0);
    chk("arst_cnt", |cnt_a, 0);
    chk("arst_cnt_b", |cnt_b, 0);
    sig = 10'h002;
    repeat (2) tick();
    chk("in_rst_lvl", lvl_a, 0);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("rel%0d_pul", e), pul_a, 0);
      chk($sformatf("rel%0d_lvl", e), lvl_a, 0);
    end
    tick();
    chk("rel6_lvl", lvl_a, 10'h002);
    chk("rel6_pul", pul_a, 10'h002);
    chk("rel6_flg", flg_a, 10'h002);
    chk("rel6_cnt1", ca(1), 1);
    tick();
    chk("rel7_pul", pul_a, 0);

    // ch2 clear handling
    sig[2] = 1'b1;
    watch(2, ea, na, eb, ez);
    chk("c2_rise_lat", ea, 6);
    chk("c2_rise_cnt", ca(2), 1);
    sig[2] = 1'b0;
    watch(2, ea, na, eb, ez);
    chk("c2_fall_lat", ea, 6);
    chk("c2_fall_cnt", ca(2), 2);
    chk("c2_fall_cnt_b", cb(2), 2);
    sig[2] = 1'b1;
    repeat (5) tick();
    clr_ch = 10'h004;
    tick();
    clr_ch = '0;
    chk("c2_same_pul", pul_a[2], 1);
    chk("c2_same_flg", flg_a[2], 1);
    chk("c2_same_cnt", ca(2), 1);
    chk("c2_same_cnt_b", cb(2), 1);
    tick();
    chk("c2_pul_width", pul_a[2], 0);
    clr_ch = 10'h004;
    tick();
    clr_ch = '0;
    chk("c2_clr_flg", flg_a[2], 0);
    chk("c2_clr_cnt", ca(2), 0);
    chk("c2_clr_lvl", lvl_a, 10'h006);
    chk("c2_clr_flg1", flg_a[1], 1);
    chk("c2_clr_cnt1", ca(1), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("gclr_flg", flg_a, 0);
    chk("gclr_any", any_a, 0);
    chk("gclr_cnt", |cnt_a, 0);
    chk("gclr_lvl", lvl_a, 10'h006);
    chk("gclr_flg_b", flg_b, 0);

    // ch4 falling-only mode, then off, then a mode change on the toggling edge
    sig[4] = 1'b1;
    watch(4, ea, na, eb, ez);
    chk("m10_rise_npul", na, 0);
    chk("m10_rise_lvl", lvl_a[4], 1);
    chk("m10_rise_flg", flg_a[4], 0);
    sig[4] = 1'b0;
    watch(4, ea, na, eb, ez);
    chk("m10_fall_lat", ea, 6);
    chk("m10_fall_npul", na, 1);
    chk("m10_fall_cnt", ca(4), 1);
    chk("m10_fall_flg", flg_a[4], 1);
    set_mode(4, 2'b00);
    sig[4] = 1'b1;
    watch(4, ea, na, eb, ez);
    chk("m00_npul", na, 0);
    chk("m00_lvl", lvl_a[4], 1);
    chk("m00_cnt", ca(4), 1);
    sig[4] = 1'b0;
    repeat (5) tick();
    chk("mchg_pre_lvl", lvl_a[4], 1);
    set_mode(4, 2'b10);
    tick();
    chk("mchg_pul", pul_a[4], 1);
    chk("mchg_lvl", lvl_a[4], 0);
    chk("mchg_cnt", ca(4), 2);

    // simultaneous rising events on channels 5..9
    for (int c = 5; c <= 9; c++) set_mode(c, 2'b01);
    sig[9:5] = 5'h1f;
    repeat (5) tick();
    chk("sim_pre_pul", pul_a, 0);
    tick();
    chk("sim_pul", pul_a, 10'h3e0);
    chk("sim_lvl", lvl_a, 10'h3e6);
    chk("sim_cnt7", ca(7), 1);
    chk("sim_cnt9", ca(9), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
